// File: rtl/cgra_cfg_loader_if.sv
// Host-side bus of the CGRA configuration loader: start/abort control,
// config word stream in, readback word stream and status out.
interface cgra_cfg_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output start, abort, cfg_data, cfg_valid,
        input  cfg_ready, rd_data, rd_valid, busy, done, aborted
    );

    modport slave (
        input  start, abort, cfg_data, cfg_valid,
        output cfg_ready, rd_data, rd_valid, busy, done, aborted
    );
endinterface

// File: rtl/cgra_cfg_loader.sv
// Serializes host config words LSB-first into the CGRA programming chain and
// reassembles the bits displaced out of the chain into readback words.
module cgra_cfg_loader #(
    parameter int NUM_TILES     = 4,
    parameter int TILE_CFG_BITS = 32,
    parameter int WORD_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    cgra_cfg_loader_if.slave host,
    output logic             program_mode,
    output logic             jtag_data_in,
    input  logic             jtag_data_out
);
    localparam int NUM_WORDS = NUM_TILES * TILE_CFG_BITS / WORD_W;
    localparam int BW        = $clog2(WORD_W);
    localparam int CW        = $clog2(NUM_WORDS + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     word_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rd_shreg;
    logic              last_bit;
    logic              more_words;
    logic              ready;
    logic              accept;

    assign last_bit   = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign more_words = (word_cnt != WORD_LAST);
    // Ready comes from state/counters only; abort still beats a handshake.
    assign ready      = (state == LOAD) || (last_bit && more_words);
    assign accept     = ready && host.cfg_valid && !host.abort;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (host.start) state_nxt = LOAD;
            LOAD: begin
                if (host.abort)  state_nxt = IDLE;
                else if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (host.abort) state_nxt = IDLE;
                else if (last_bit) begin
                    if (!more_words)  state_nxt = DONE;
                    else if (!accept) state_nxt = LOAD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        host.cfg_ready = ready;
        host.busy      = (state != IDLE);
        host.done      = (state == DONE);
        program_mode   = (state == SHIFT);
        jtag_data_in   = program_mode & shreg[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt      <= '0;
            word_cnt     <= '0;
            shreg        <= '0;
            rd_shreg     <= '0;
            host.rd_data <= '0;
            host.rd_valid <= 1'b0;
            host.aborted <= 1'b0;
        end else begin
            host.rd_valid <= 1'b0;
            host.aborted  <= (state != IDLE) && host.abort;
            case (state)
                IDLE: if (host.start) word_cnt <= '0;
                LOAD: begin
                    if (accept) begin
                        shreg   <= host.cfg_data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // An aborted word is dropped: no readback, no count update.
                    if (!host.abort) begin
                        shreg    <= shreg >> 1;
                        rd_shreg <= {jtag_data_out, rd_shreg[WORD_W-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            host.rd_valid <= 1'b1;
                            host.rd_data  <= {jtag_data_out, rd_shreg[WORD_W-1:1]};
                            bit_cnt       <= '0;
                            if (more_words) word_cnt <= word_cnt + 1'b1;
                            if (accept)     shreg    <= host.cfg_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
